// File: rtl/mul32_seq_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : mul32_seq_ctrl_if
// Description : Signal bundle between the execute stage, the mul32_seq_ctrl
//               sequencer and the shared 16x16 multiplier instance.
//               Request/response handshake, flush, and the multiplier
//               operand/mode/product path.
//               master : execute-stage side, including the shared multiplier
//                        that returns mul_prod.
//               slave  : the sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mul32_seq_ctrl_if;
    // request channel
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    // response channel
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;
    // shared multiplier path
    logic [15:0] mul_ain;
    logic [15:0] mul_bin;
    logic        mul_ss;
    logic        mul_us;
    logic        mul_su;
    logic        mul_uu;
    logic [31:0] mul_prod;

    modport master (
        output req_valid, req_op, req_a, req_b, flush, resp_ready, mul_prod,
        input  req_ready, resp_valid, resp_data, busy,
        input  mul_ain, mul_bin, mul_ss, mul_us, mul_su, mul_uu
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush, resp_ready, mul_prod,
        output req_ready, resp_valid, resp_data, busy,
        output mul_ain, mul_bin, mul_ss, mul_us, mul_su, mul_uu
    );
endinterface

`default_nettype wire

// File: rtl/mul32_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : mul32_seq_ctrl
// Description : Sequencer computing RV32M MUL/MULH/MULHSU/MULHU with a shared
//               16x16 multiplier. Four partial products (Al*Bl, Al*Bh, Ah*Bl,
//               Ah*Bh) are issued one per step and accumulated into a 64-bit
//               register; the 32-bit result is returned on a valid/ready
//               handshake. A flush aborts any operation in flight.
// Parameters  : MUL_STAGES - pipeline registers in the multiplier path (0..2);
//               each step holds its operands MUL_STAGES+1 cycles.
// Macros      : MUL_EARLY_EXIT_EN - when defined, MUL (low word) skips the
//               Ah*Bh step, which only contributes to bits 63:32.
// Ports       : clk, rst (synchronous, active high)
//               bus (mul32_seq_ctrl_if.slave):
//                 req_valid/req_ready/req_op/req_a/req_b - request
//                 flush                                  - abort
//                 resp_valid/resp_ready/resp_data        - response
//                 busy                                   - not idle
//                 mul_ain/mul_bin/mul_{ss,su,us,uu}      - to multiplier
//                 mul_prod                               - from multiplier
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul32_seq_ctrl #(
    parameter int unsigned MUL_STAGES = 0
) (
    input  logic             clk,
    input  logic             rst,
    mul32_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_WAIT_LAST = 2'(MUL_STAGES);
    localparam logic [1:0] c_OP_MUL    = 2'b00;
    localparam logic [1:0] c_OP_MULH   = 2'b01;
    localparam logic [1:0] c_OP_MULHSU = 2'b10;

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sa;
    logic        r_sb;
    logic [63:0] r_acc;
    logic [1:0]  r_step;
    logic [1:0]  r_wait;
    logic [31:0] r_resp_data;

    logic        w_step_end;
    logic        w_last_step;
    logic        w_ain_signed;
    logic        w_bin_signed;
    logic [15:0] w_ain;
    logic [15:0] w_bin;
    logic [5:0]  w_shamt;
    logic [63:0] w_prod_ext;
    logic [63:0] w_acc_sum;

    // The step ends when the operands have been held long enough for the
    // multiplier pipeline to present their product.
    assign w_step_end = (r_wait == c_WAIT_LAST);

`ifdef MUL_EARLY_EXIT_EN
    assign w_last_step = (r_step == 2'd3) ||
                         ((r_step == 2'd2) && (r_op == c_OP_MUL));
`else
    assign w_last_step = (r_step == 2'd3);
`endif

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next state, handshake outputs and step operand selection
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.busy       = 1'b1;
        w_ain          = 16'd0;
        w_bin          = 16'd0;
        w_ain_signed   = 1'b0;
        w_bin_signed   = 1'b0;
        w_shamt        = 6'd0;

        case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) begin
                    w_state_next = ST_CALC;
                end
            end

            ST_CALC: begin
                // step[1] selects the A half, step[0] the B half; a half is
                // treated as signed only when it is the upper half of a
                // signed operand.
                w_ain        = r_step[1] ? r_a[31:16] : r_a[15:0];
                w_bin        = r_step[0] ? r_b[31:16] : r_b[15:0];
                w_ain_signed = r_step[1] & r_sa;
                w_bin_signed = r_step[0] & r_sb;
                case (r_step)
                    2'd0:    w_shamt = 6'd0;
                    2'd3:    w_shamt = 6'd32;
                    default: w_shamt = 6'd16;
                endcase
                if (bus.flush) begin
                    w_state_next = ST_IDLE;
                end else if (w_step_end && w_last_step) begin
                    w_state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                bus.resp_valid = 1'b1;
                if (bus.flush || bus.resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.mul_ain   = w_ain;
    assign bus.mul_bin   = w_bin;
    assign bus.mul_ss    =  w_ain_signed &  w_bin_signed;
    assign bus.mul_su    =  w_ain_signed & ~w_bin_signed;
    assign bus.mul_us    = ~w_ain_signed &  w_bin_signed;
    assign bus.mul_uu    = ~w_ain_signed & ~w_bin_signed;
    assign bus.resp_data = r_resp_data;

    // A 16x16 product with any signed input is a signed 32-bit value; an
    // unsigned-by-unsigned product may use bit 31 as magnitude.
    assign w_prod_ext = (w_ain_signed | w_bin_signed) ?
                        {{32{bus.mul_prod[31]}}, bus.mul_prod} :
                        {32'd0, bus.mul_prod};
    assign w_acc_sum  = r_acc + (w_prod_ext << w_shamt);

    //--------------------------------------------------------------------------
    // Operand capture, step sequencing and accumulation
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 2'd0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_acc       <= 64'd0;
            r_step      <= 2'd0;
            r_wait      <= 2'd0;
            r_resp_data <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op   <= bus.req_op;
                        r_a    <= bus.req_a;
                        r_b    <= bus.req_b;
                        r_sa   <= (bus.req_op == c_OP_MULH) ||
                                  (bus.req_op == c_OP_MULHSU);
                        r_sb   <= (bus.req_op == c_OP_MULH);
                        r_acc  <= 64'd0;
                        r_step <= 2'd0;
                        r_wait <= 2'd0;
                    end
                end

                ST_CALC: begin
                    if (bus.flush) begin
                        r_step <= 2'd0;
                        r_wait <= 2'd0;
                    end else if (w_step_end) begin
                        r_acc  <= w_acc_sum;
                        r_step <= r_step + 2'd1;
                        r_wait <= 2'd0;
                        // Result is captured from the final sum so it is
                        // stable for the whole time the response waits.
                        if (w_last_step) begin
                            r_resp_data <= (r_op == c_OP_MUL) ? w_acc_sum[31:0]
                                                              : w_acc_sum[63:32];
                        end
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
